// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO burst reader slice.
// Exports: rd_state_e (reader FSM states), SKID_DEPTH (output buffer entries).
`timescale 1ns/1ps
package fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   localparam int SKID_DEPTH = 3;

endpackage

// File: rtl/fifo_skid_buf.sv
// Three-entry circular buffer holding words returned by the FIFO, tagged with last.
// Ports: clk, rst_n, push/push_data/push_last in, pop in, occ out, head_data/head_last out.
`timescale 1ns/1ps
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_last,
   input  logic                  pop,
   output logic [1:0]            occ,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  head_last
);

   localparam logic [1:0] LAST_IDX = 2'(SKID_DEPTH - 1);

   logic [DATA_WIDTH-1:0] data_q [SKID_DEPTH];
   logic                  last_q [SKID_DEPTH];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            data_q[i] <= '0;
            last_q[i] <= 1'b0;
         end
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         occ    <= 2'd0;
      end else begin
         if (push) begin
            data_q[wr_ptr] <= push_data;
            last_q[wr_ptr] <= push_last;
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         unique case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign head_data = data_q[rd_ptr];
   assign head_last = last_q[rd_ptr];

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(push && !pop && (occ == LAST_IDX + 2'd1))
   );

   a_no_underflow: assert property (
      @(posedge clk) disable iff (!rst_n)
      !(pop && (occ == 2'd0))
   );

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side master for a STD-mode FIFO: drains N words per request onto a
// valid/ready stream with last. Ports: clk, rst_n, req_vld/req_len/req_rdy,
// fifo_empty/fifo_ren/fifo_dout, m_data/m_valid/m_ready/m_last, busy, done.
`timescale 1ns/1ps
module fifo_burst_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_DEPTH = 512,
   parameter int LEN_WIDTH  = $clog2(DATA_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_vld,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  req_rdy,
   input  logic                  fifo_empty,
   output logic                  fifo_ren,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   rd_state_e            state;
   logic [LEN_WIDTH-1:0] remaining;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] rcvd;
   logic                 inflight;
   logic [1:0]           occ;
   logic [2:0]           fill;
   logic                 push_last;
   logic                 head_last;
   logic                 pop;

   // Reserve a slot for the word still in flight so the buffer cannot
   // overflow; m_ready is deliberately kept out of this path.
   assign fill     = {1'b0, occ} + {2'b00, inflight};
   assign fifo_ren = (state == RUN) & ~fifo_empty &
                     (remaining != '0) & (fill < 3'd3);

   assign push_last = (rcvd == len_q - LEN_WIDTH'(1));
   assign m_valid   = (occ != 2'd0);
   assign m_last    = m_valid & head_last;
   assign pop       = m_valid & m_ready;
   assign req_rdy   = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
         len_q     <= '0;
         rcvd      <= '0;
         inflight  <= 1'b0;
         done      <= 1'b0;
      end else begin
         inflight <= fifo_ren;
         done     <= 1'b0;
         if (inflight) begin
            rcvd <= rcvd + LEN_WIDTH'(1);
         end
         unique case (state)
            IDLE: begin
               if (req_vld) begin
                  if (req_len != '0) begin
                     len_q     <= req_len;
                     remaining <= req_len;
                     rcvd      <= '0;
                     state     <= RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (fifo_ren) begin
                  remaining <= remaining - LEN_WIDTH'(1);
                  if (remaining == LEN_WIDTH'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && m_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fifo_skid_buf #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (fifo_dout),
      .push_last (push_last),
      .pop       (pop),
      .occ       (occ),
      .head_data (m_data),
      .head_last (head_last)
   );

   a_fill_bound: assert property (
      @(posedge clk) disable iff (!rst_n) fill <= 3'd3
   );

endmodule
